// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: ID/EX/MEM/WB hazard inputs and pipeline control outputs.
// The slave modport is the sequencer; the master modport is the pipeline side.
// With HAZARD_FWD_EN defined the bundle also carries the EX forwarding selects.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             uses_rs_ID;
  logic             uses_rt_ID;
  logic             mul_ID;
  logic [4:0]       rd_EX;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic [4:0]       rd_MEM;
  logic             RegWrite_MEM;
  logic [4:0]       rd_WB;
  logic             RegWrite_WB;
  logic             PCSrc_MEM;
  logic             JR_WB;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_Bubble;
  logic             Flush_IFID;
  logic             Flush_IDEX;
  logic             Flush_EXMEM;
  logic             mul_start;
  logic             mul_abort;
  logic [CNT_W-1:0] stall_count;
`ifdef HAZARD_FWD_EN
  logic [1:0]       FwdA_EX;
  logic [1:0]       FwdB_EX;
`endif

  modport slave (
    input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, mul_ID,
    input  rd_EX, RegWrite_EX, MemRead_EX,
    input  rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB,
    input  PCSrc_MEM, JR_WB,
    output PCWrite, IFIDWrite, IDEX_Bubble,
    output Flush_IFID, Flush_IDEX, Flush_EXMEM,
    output mul_start, mul_abort, stall_count
`ifdef HAZARD_FWD_EN
    , output FwdA_EX, FwdB_EX
`endif
  );

  modport master (
    output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, mul_ID,
    output rd_EX, RegWrite_EX, MemRead_EX,
    output rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB,
    output PCSrc_MEM, JR_WB,
    input  PCWrite, IFIDWrite, IDEX_Bubble,
    input  Flush_IFID, Flush_IDEX, Flush_EXMEM,
    input  mul_start, mul_abort, stall_count
`ifdef HAZARD_FWD_EN
    , input FwdA_EX, FwdB_EX
`endif
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage MIPS core: RAW hazard stalls, multi-cycle
// multiply sequencing, branch/JR redirect flushes and a saturating stall counter.
// Optional feature macro: HAZARD_FWD_EN -- adds EX forwarding selects and reduces
// data stalls to the single load-use bubble. Without it, any used source that
// matches an in-flight destination (EX, MEM or WB) stalls ID.
module hazard_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic             Clk,
  input logic             Rst,
  hazard_sequencer_if.slave hs
);

  typedef enum logic {RUN, MUL_BUSY} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic             mul_done_q, mul_done_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic redirect;
  logic data_hazard;
  logic pc_we, ifid_we, bubble;
  logic flush_ifid, flush_idex, flush_exmem;
  logic start_p, abort_p;

  // Register $0 is hardwired zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d,
                                     input logic we);
    return we && (d != 5'd0) && (d == r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign redirect = hs.PCSrc_MEM | hs.JR_WB;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign data_hazard = hs.MemRead_EX &&
    ((hs.uses_rs_ID && reg_match(hs.rs_ID, hs.rd_EX, hs.RegWrite_EX)) ||
     (hs.uses_rt_ID && reg_match(hs.rt_ID, hs.rd_EX, hs.RegWrite_EX)));
`else
  assign data_hazard =
    (hs.uses_rs_ID && (reg_match(hs.rs_ID, hs.rd_EX,  hs.RegWrite_EX)  ||
                       reg_match(hs.rs_ID, hs.rd_MEM, hs.RegWrite_MEM) ||
                       reg_match(hs.rs_ID, hs.rd_WB,  hs.RegWrite_WB))) ||
    (hs.uses_rt_ID && (reg_match(hs.rt_ID, hs.rd_EX,  hs.RegWrite_EX)  ||
                       reg_match(hs.rt_ID, hs.rd_MEM, hs.RegWrite_MEM) ||
                       reg_match(hs.rt_ID, hs.rd_WB,  hs.RegWrite_WB)));
`endif

  // Next state and control outputs; redirect beats multiply beats data hazard.
  // mul_done_q stops the finished multiply from restarting during the cycle it
  // still sits in ID (or while a data stall holds it there).
  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    mul_done_d  = mul_done_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    bubble      = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    start_p     = 1'b0;
    abort_p     = 1'b0;
    if (redirect) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      abort_p     = (state_q == MUL_BUSY);
      state_d     = RUN;
      mul_cnt_d   = 4'd0;
      mul_done_d  = 1'b0;
    end else if (state_q == MUL_BUSY) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      bubble    = 1'b1;
      mul_cnt_d = mul_cnt_q - 4'd1;
      if (mul_cnt_q <= 4'd1) begin
        state_d    = RUN;
        mul_cnt_d  = 4'd0;
        mul_done_d = 1'b1;
      end
    end else if (hs.mul_ID && !mul_done_q) begin
      start_p = 1'b1;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (MUL_LATENCY > 1) begin
        state_d   = MUL_BUSY;
        mul_cnt_d = MUL_LOAD;
      end else begin
        mul_done_d = 1'b1;
      end
    end else if (data_hazard) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
    end else begin
      mul_done_d = 1'b0;
    end
    if (Rst) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      bubble      = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      start_p     = 1'b0;
      abort_p     = 1'b0;
    end
  end

  // State, multiply counter and saturating stall counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      mul_done_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_done_q <= mul_done_d;
      if (!pc_we) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign hs.PCWrite     = pc_we;
  assign hs.IFIDWrite   = ifid_we;
  assign hs.IDEX_Bubble = bubble;
  assign hs.Flush_IFID  = flush_ifid;
  assign hs.Flush_IDEX  = flush_idex;
  assign hs.Flush_EXMEM = flush_exmem;
  assign hs.mul_start   = start_p;
  assign hs.mul_abort   = abort_p;
  assign hs.stall_count = stall_cnt_q;

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q;
  logic       unused_wb;

  assign unused_wb = ^{hs.rd_WB, hs.RegWrite_WB};

  // Select chosen in ID and carried into EX with the instruction: a producer now
  // in EX will sit in EX/MEM next cycle (10), one now in MEM in MEM/WB (01).
  always_ff @(posedge Clk) begin
    if (Rst || !ifid_we || flush_idex) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= !hs.uses_rs_ID ? 2'b00 :
                 reg_match(hs.rs_ID, hs.rd_EX,  hs.RegWrite_EX)  ? 2'b10 :
                 reg_match(hs.rs_ID, hs.rd_MEM, hs.RegWrite_MEM) ? 2'b01 : 2'b00;
      fwd_b_q <= !hs.uses_rt_ID ? 2'b00 :
                 reg_match(hs.rt_ID, hs.rd_EX,  hs.RegWrite_EX)  ? 2'b10 :
                 reg_match(hs.rt_ID, hs.rd_MEM, hs.RegWrite_MEM) ? 2'b01 : 2'b00;
    end
  end

  assign hs.FwdA_EX = fwd_a_q;
  assign hs.FwdB_EX = fwd_b_q;
`endif

endmodule
